mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 143 ++++++++++++++
 tb/tb_mul_div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit implementing the RV32M funct3 operation set.
// Fixed latency of XLEN+1 cycles from accept to DONE, with no early-out.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [2:0]      MDU_SEL,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] MDU_RESULT
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic              neg_q, neg_d;
    logic              asgn_q, asgn_d;
    logic              bzero_q, bzero_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign MDU_RESULT = result_q;

    // Signed operands: MULH/MULHSU/DIV/REM for srcA, MULH/DIV/REM for srcB.
    assign a_sgn = (MDU_SEL == 3'b001) || (MDU_SEL == 3'b010) ||
                   (MDU_SEL == 3'b100) || (MDU_SEL == 3'b110);
    assign b_sgn = (MDU_SEL == 3'b001) || (MDU_SEL == 3'b100) || (MDU_SEL == 3'b110);
    assign a_neg = a_sgn & srcA[XLEN-1];
    assign b_neg = b_sgn & srcB[XLEN-1];
    assign a_mag = a_neg ? -srcA : srcA;
    assign b_mag = b_neg ? -srcB : srcB;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign ge       = ~diff[XLEN];
    assign div_next = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = '0;
        unique case (op_q)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = bzero_q ? '1 : (neg_q ? -quo : quo);
            default:                fix_val = bzero_q ? araw_q : (asgn_q ? -rem : rem);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        araw_d   = araw_q;
        neg_d    = neg_q;
        asgn_d   = asgn_q;
        bzero_d  = bzero_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = CALC;
                    op_d    = MDU_SEL;
                    opnd_d  = b_mag;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    araw_d  = srcA;
                    neg_d   = a_neg ^ b_neg;
                    asgn_d  = a_neg;
                    bzero_d = (srcB == '0);
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                result_d = fix_val;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            araw_q   <= '0;
            neg_q    <= 1'b0;
            asgn_q   <= 1'b0;
            bzero_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            araw_q   <= araw_d;
            neg_q    <= neg_d;
            asgn_q   <= asgn_d;
            bzero_q  <= bzero_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (XLEN=32): directed vectors push expected results,
// and a negedge monitor checks each DONE pulse for value, timing and result hold.
module tb_mul_div_unit;

    localparam int unsigned XLEN = 32;
    localparam int LAT = XLEN + 1;

    logic            CLK = 1'b0;
    logic            RST, START, BUSY, DONE;
    logic [XLEN-1:0] srcA, srcB, MDU_RESULT;
    logic [2:0]      MDU_SEL;

    typedef struct {
        logic [XLEN-1:0] res;
        int              done_edge;
        string           name;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              edge_cnt = 0;
    logic            hold_en = 1'b0;
    logic [XLEN-1:0] exp_hold = '0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .START(START), .srcA(srcA), .srcB(srcB),
        .MDU_SEL(MDU_SEL), .BUSY(BUSY), .DONE(DONE), .MDU_RESULT(MDU_RESULT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (BUSY !== 1'b0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", {31'b0, BUSY}, '0);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic do_op(input logic [2:0] sel, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] r, input string nm);
        int acc_edge;
        wait_idle();
        START = 1'b1; MDU_SEL = sel; srcA = a; srcB = b;
        acc_edge = edge_cnt + 1;
        sb.push_back('{res: r, done_edge: acc_edge + LAT, name: nm});
        @(negedge CLK);
        START = 1'b0; srcA = $urandom; srcB = $urandom; MDU_SEL = 3'($urandom_range(0, 7));
        chk({nm, "_busy"}, {31'b0, BUSY}, 32'd1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'b0, DONE}, '0);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, MDU_RESULT, e.res);
                    chk({e.name, "_edge"}, edge_cnt, e.done_edge);
                    chk({e.name, "_busy_clr"}, {31'b0, BUSY}, '0);
                    exp_hold = e.res;
                end
            end else if (hold_en) begin
                chk("result_hold", MDU_RESULT, exp_hold);
            end
        end
    end

    initial begin
        int a0;
        int guard;
        RST = 1'b1; START = 1'b0; srcA = '0; srcB = '0; MDU_SEL = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_busy", {31'b0, BUSY}, '0);
        chk("rst_done", {31'b0, DONE}, '0);
        chk("rst_result", MDU_RESULT, '0);
        exp_hold = '0;
        hold_en = 1'b1;

        do_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        do_op(3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_min2");
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1m1");
        do_op(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift");
        do_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
        do_op(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2");
        do_op(3'b101, 32'd100,       32'd7,         32'd14,        "divu_100_7");
        do_op(3'b111, 32'd100,       32'd7,         32'd2,         "remu_100_7");
        do_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
        do_op(3'b111, 32'd5,         32'd0,         32'd5,         "remu_by0");
        do_op(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_neg_by0");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_neg_by0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // Reset in the middle of a DIV, with a START that must be discarded.
        wait_idle();
        START = 1'b1; MDU_SEL = 3'b100; srcA = 32'd1000; srcB = 32'd3;
        a0 = edge_cnt + 1;
        @(negedge CLK);
        START = 1'b0;
        guard = 0;
        while (edge_cnt < a0 + 9 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        hold_en = 1'b0;
        RST = 1'b1; START = 1'b1;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        chk("midrst_edge", edge_cnt, a0 + 10);
        chk("midrst_busy", {31'b0, BUSY}, '0);
        chk("midrst_result", MDU_RESULT, '0);
        chk("midrst_done", {31'b0, DONE}, '0);
        exp_hold = '0;
        hold_en = 1'b1;
        repeat (40) @(negedge CLK);
        chk("midrst_start_discarded", {31'b0, BUSY}, '0);
        do_op(3'b101, 32'd1000, 32'd3, 32'd333, "divu_after_rst");

        // START held high through a whole MUL: one accept, next accept right after DONE.
        wait_idle();
        START = 1'b1; MDU_SEL = 3'b000; srcA = 32'd3; srcB = 32'd4;
        a0 = edge_cnt + 1;
        sb.push_back('{res: 32'd12, done_edge: a0 + LAT, name: "mul_held_1"});
        @(negedge CLK);
        srcA = 32'd5; srcB = 32'd6;
        sb.push_back('{res: 32'd30, done_edge: a0 + LAT + 1 + LAT, name: "mul_held_2"});
        guard = 0;
        while (edge_cnt < a0 + LAT + 1 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        START = 1'b0;
        chk("held_reaccept_busy", {31'b0, BUSY}, 32'd1);
        guard = 0;
        while (edge_cnt < a0 + 2 * LAT && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        chk("held_result_kept", MDU_RESULT, 32'd12);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
